// File: rtl/alu_exec_ctrl.sv
// Execution sequencer for the 16-bit ALU datapath: register read, ALU or
// multiplier/divider execution, and register write-back of one instruction.
module alu_exec_ctrl #(
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_instr_valid,
   output logic        o_instr_ready,
   input  logic [31:0] i_instr,
   output logic [4:0]  o_rf_raddr_a,
   output logic [4:0]  o_rf_raddr_b,
   input  logic [15:0] i_rf_rdata_a,
   input  logic [15:0] i_rf_rdata_b,
   output logic [5:0]  o_alu_sel,
   output logic [15:0] o_op_a,
   output logic [15:0] o_op_b,
   input  logic [15:0] i_alu_res,
   output logic        o_md_start,
   input  logic        i_md_done,
   input  logic [31:0] i_md_res,
   output logic        o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [15:0] o_rf_wdata,
   output logic        o_done,
   output logic        o_illegal,
   output logic        o_timeout
);

   localparam int unsigned CntW = $clog2(MD_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MD_TIMEOUT);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   localparam logic [5:0] OpMov  = 6'h00;
   localparam logic [5:0] OpAdd  = 6'h04;
   localparam logic [5:0] OpMul  = 6'h07;
   localparam logic [5:0] OpDiv  = 6'h08;
   localparam logic [5:0] OpLrsh = 6'h10;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StExec,
      StWaitMd,
      StWb,
      StWbHi,
      StErr
   } state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [31:0]     r_instr;
   logic [15:0]     r_op_a;
   logic [15:0]     r_op_b;
   logic [15:0]     r_result;
   logic [15:0]     r_md_hi;
   logic [CntW-1:0] r_md_cnt;

   logic [5:0] w_in_op;
   logic [5:0] w_op;
   logic       w_accept;
   logic       w_in_legal;
   logic       w_is_md;
   logic       w_is_mul;
   logic       w_unused_fields;

   assign w_in_op    = i_instr[31:26];
   assign w_op       = r_instr[31:26];
   assign w_accept   = (r_state == StIdle) && i_instr_valid;
   assign w_in_legal = (w_in_op == OpMov) || ((w_in_op >= OpAdd) && (w_in_op <= OpLrsh));
   assign w_is_mul   = (w_op == OpMul);
   assign w_is_md    = w_is_mul || (w_op == OpDiv);

   assign w_unused_fields = ^r_instr[15:10];

   // Read addresses go out in the accept cycle so data is back during READ.
   assign o_rf_raddr_a = w_accept ? i_instr[4:0] : r_instr[4:0];
   assign o_rf_raddr_b = w_accept ? i_instr[9:5] : r_instr[9:5];
   assign o_alu_sel    = w_op;
   assign o_op_a       = r_op_a;
   assign o_op_b       = r_op_b;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_instr  <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_result <= '0;
         r_md_hi  <= '0;
         r_md_cnt <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_instr <= i_instr;
               end
            end
            StRead: begin
               r_op_a <= i_rf_rdata_a;
               r_op_b <= i_rf_rdata_b;
            end
            StExec: begin
               r_result <= (w_op == OpMov) ? r_op_a : i_alu_res;
               r_md_cnt <= CntOne;
            end
            StWaitMd: begin
               if (i_md_done) begin
                  r_result <= i_md_res[15:0];
                  r_md_hi  <= i_md_res[31:16];
               end else begin
                  r_md_cnt <= r_md_cnt + CntOne;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_state_next  = r_state;
      o_instr_ready = 1'b0;
      o_md_start    = 1'b0;
      o_rf_we       = 1'b0;
      o_rf_waddr    = '0;
      o_rf_wdata    = '0;
      o_done        = 1'b0;
      o_illegal     = 1'b0;
      o_timeout     = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_instr_ready = 1'b1;
            if (i_instr_valid) begin
               w_state_next = w_in_legal ? StRead : StErr;
            end
         end
         StRead: begin
            w_state_next = StExec;
         end
         StExec: begin
            if (w_is_md) begin
               o_md_start   = 1'b1;
               w_state_next = StWaitMd;
            end else begin
               w_state_next = StWb;
            end
         end
         StWaitMd: begin
            // A done arriving on the limit cycle still counts as success.
            if (i_md_done) begin
               w_state_next = StWb;
            end else if (r_md_cnt == CntMax) begin
               o_timeout    = 1'b1;
               o_done       = 1'b1;
               w_state_next = StIdle;
            end
         end
         StWb: begin
            o_rf_we      = 1'b1;
            o_rf_waddr   = r_instr[20:16];
            o_rf_wdata   = r_result;
            o_done       = !w_is_mul;
            w_state_next = w_is_mul ? StWbHi : StIdle;
         end
         StWbHi: begin
            o_rf_we      = 1'b1;
            o_rf_waddr   = r_instr[25:21];
            o_rf_wdata   = r_md_hi;
            o_done       = 1'b1;
            w_state_next = StIdle;
         end
         StErr: begin
            o_illegal    = 1'b1;
            o_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register-file/ALU/MUL-DIV environment plus a
// per-cycle expected timeline derived from the instruction latency rules.
module tb_alu_exec_ctrl;

   localparam int MdTimeout = 64;
   localparam int MaxCyc    = 2048;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [4:0]  rf_raddr_a, rf_raddr_b;
   logic [15:0] rf_rdata_a, rf_rdata_b;
   logic [5:0]  alu_sel;
   logic [15:0] op_a, op_b, alu_res;
   logic        md_start, md_done;
   logic [31:0] md_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        done, illegal, timeout;

   alu_exec_ctrl #(.MD_TIMEOUT(MdTimeout)) dut (
      .i_clk(clk), .i_reset(reset), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
      .i_instr(instr), .o_rf_raddr_a(rf_raddr_a), .o_rf_raddr_b(rf_raddr_b),
      .i_rf_rdata_a(rf_rdata_a), .i_rf_rdata_b(rf_rdata_b), .o_alu_sel(alu_sel),
      .o_op_a(op_a), .o_op_b(op_b), .i_alu_res(alu_res), .o_md_start(md_start),
      .i_md_done(md_done), .i_md_res(md_res), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr),
      .o_rf_wdata(rf_wdata), .o_done(done), .o_illegal(illegal), .o_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Operation table of the instruction set.
   function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         6'd0:    return a;
         6'd4:    return b + a;
         6'd5:    return b - a;
         6'd6:    return 16'h0 - a;
         6'd9:    return b | a;
         6'd10:   return b ^ a;
         6'd11:   return ~(b & a);
         6'd12:   return ~(b | a);
         6'd13:   return ~(b ^ a);
         6'd14:   return ~a;
         6'd15:   return b << a;
         6'd16:   return b >> a;
         default: return 16'h0;
      endcase
   endfunction

   // Divider unit returns all-ones on divide-by-zero.
   function automatic logic [15:0] div16(input logic [15:0] b, input logic [15:0] a);
      return (a == 16'h0) ? 16'hFFFF : b / a;
   endfunction

   function automatic logic [31:0] mk(input int op, input int rd2, input int rd1,
                                      input int rs2, input int rs1);
      return {op[5:0], rd2[4:0], rd1[4:0], 6'h2A, rs2[4:0], rs1[4:0]};
   endfunction

   assign alu_res = alu_f(alu_sel, op_a, op_b);

   // Environment: register file with registered read, MUL/DIV unit.
   logic [15:0] env_rf [32];
   int          md_lat  = 0;
   int          md_cnt  = 0;
   bit          md_busy = 0;
   bit          stray   = 0;

   initial begin
      rf_rdata_a = '0;
      rf_rdata_b = '0;
      md_done    = 1'b0;
      md_res     = '0;
   end

   always begin
      logic [4:0]  s_ra, s_rb, s_wa;
      logic [15:0] s_wd, s_a, s_b;
      logic        s_we, s_start;
      logic [5:0]  s_sel;
      @(negedge clk);
      s_ra = rf_raddr_a; s_rb = rf_raddr_b; s_we = rf_we; s_wa = rf_waddr; s_wd = rf_wdata;
      s_start = md_start; s_a = op_a; s_b = op_b; s_sel = alu_sel;
      @(posedge clk);
      #1;
      if (s_we) env_rf[s_wa] = s_wd;
      rf_rdata_a = env_rf[s_ra];
      rf_rdata_b = env_rf[s_rb];
      md_done = 1'b0;
      if (s_start) begin
         md_busy = 1;
         md_cnt  = 0;
         md_res  = (s_sel == 6'd7) ? 32'(s_a) * 32'(s_b) : {16'h0, div16(s_b, s_a)};
      end
      if (md_busy) begin
         md_cnt++;
         if (md_lat != 0 && md_cnt == md_lat) begin
            md_done = 1'b1;
            md_busy = 0;
         end
      end
      if (stray) begin
         md_done = 1'b1;
         md_res  = $urandom;
         stray   = 0;
      end
   end

   // Expected per-cycle timeline and architectural register model.
   logic [15:0] model_rf [32];
   bit          exp_we [MaxCyc];
   logic [4:0]  exp_wa [MaxCyc];
   logic [15:0] exp_wd [MaxCyc];
   bit exp_done [MaxCyc], exp_ill [MaxCyc], exp_to [MaxCyc], exp_rdy [MaxCyc];
   bit exp_start [MaxCyc], exp_opchk [MaxCyc];
   logic [15:0] exp_opa [MaxCyc], exp_opb [MaxCyc];
   logic [5:0]  exp_sel [MaxCyc];

   task automatic clear_from(input int c);
      for (int k = c; k < MaxCyc; k++) begin
         exp_we[k] = 0; exp_done[k] = 0; exp_ill[k] = 0; exp_to[k] = 0; exp_rdy[k] = 1;
         exp_start[k] = 0; exp_opchk[k] = 0;
      end
   endtask

   task automatic put_write(input int c, input logic [4:0] a, input logic [15:0] d);
      exp_we[c] = 1; exp_wa[c] = a; exp_wd[c] = d;
      model_rf[a] = d;
   endtask

   always @(negedge clk) begin
      if (cyc < MaxCyc) begin
         check("instr_ready", 32'(instr_ready), 32'(exp_rdy[cyc]));
         check("rf_we", 32'(rf_we), 32'(exp_we[cyc]));
         check("done", 32'(done), 32'(exp_done[cyc]));
         check("illegal", 32'(illegal), 32'(exp_ill[cyc]));
         check("timeout", 32'(timeout), 32'(exp_to[cyc]));
         check("md_start", 32'(md_start), 32'(exp_start[cyc]));
         if (exp_we[cyc]) begin
            check("rf_waddr", 32'(rf_waddr), 32'(exp_wa[cyc]));
            check("rf_wdata", 32'(rf_wdata), 32'(exp_wd[cyc]));
         end
         if (exp_opchk[cyc]) begin
            check("op_a", 32'(op_a), 32'(exp_opa[cyc]));
            check("op_b", 32'(op_b), 32'(exp_opb[cyc]));
            check("alu_sel", 32'(alu_sel), 32'(exp_sel[cyc]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input int r, input logic [15:0] v);
      env_rf[r] = v;
      model_rf[r] = v;
   endtask

   // Offers one instruction for one cycle; d is the cycle its done is expected.
   task automatic issue(input logic [31:0] ins, input int lat, output int d);
      int c;
      logic [5:0]  op;
      logic [15:0] a, b, lo, hi;
      logic [31:0] p;
      op = ins[31:26];
      a  = model_rf[ins[4:0]];
      b  = model_rf[ins[9:5]];
      c  = cyc;
      md_lat = lat;
      instr = ins;
      instr_valid = 1'b1;
      if (!((op == 6'd0) || (op >= 6'd4 && op <= 6'd16))) begin
         d = c + 1;
         exp_ill[d] = 1;
      end else begin
         exp_opchk[c+2] = 1; exp_opa[c+2] = a; exp_opb[c+2] = b; exp_sel[c+2] = op;
         if (op == 6'd7 || op == 6'd8) begin
            exp_start[c+2] = 1;
            if (lat == 0 || lat > MdTimeout) begin
               d = c + 2 + MdTimeout;
               exp_to[d] = 1;
            end else begin
               p  = (op == 6'd7) ? 32'(a) * 32'(b) : {16'h0, div16(b, a)};
               lo = p[15:0];
               hi = p[31:16];
               d  = c + 3 + lat;
               put_write(d, ins[20:16], lo);
               if (op == 6'd7) begin
                  d = d + 1;
                  put_write(d, ins[25:21], hi);
               end
            end
         end else begin
            d = c + 3;
            put_write(d, ins[20:16], alu_f(op, a, b));
         end
      end
      exp_done[d] = 1;
      for (int k = c + 1; k <= d; k++) exp_rdy[k] = 0;
      tick();
      instr_valid = 1'b0;
      instr = $urandom;
   endtask

   task automatic run(input logic [31:0] ins, input int lat);
      int d;
      issue(ins, lat, d);
      while (cyc <= d) tick();
   endtask

   task automatic reset_now();
      reset = 1'b1;
      md_busy = 0;
      clear_from(cyc);
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   typedef struct {
      logic [31:0] ins;
      int          lat;
   } vec_t;

   initial begin
      vec_t vecs [$];
      int   d;
      logic [15:0] old7;
      clear_from(0);
      reset = 1'b1;
      instr_valid = 1'b0;
      instr = 32'h0;
      for (int i = 0; i < 32; i++) set_reg(i, 16'($urandom));
      set_reg(0, 16'h0000);
      set_reg(1, 16'h0005);
      set_reg(2, 16'h0003);
      set_reg(3, 16'h00FF);
      set_reg(8, 16'h8000);
      set_reg(9, 16'h0004);
      set_reg(11, 16'h1234);
      set_reg(12, 16'h0100);
      set_reg(15, 16'hABCD);
      set_reg(7, 16'h7777);
      repeat (3) tick();
      check("reset raddr_a", 32'(rf_raddr_a), 32'h0);
      check("reset op_a", 32'(op_a), 32'h0);
      check("reset alu_sel", 32'(alu_sel), 32'h0);
      check("reset rf_waddr", 32'(rf_waddr), 32'h0);
      reset = 1'b0;
      tick();

      run(mk(4, 0, 4, 2, 1), 0);
      #2 check("ADD r4", 32'(env_rf[4]), 32'h0008);
      run(mk(5, 0, 4, 2, 1), 0);
      #2 check("SUB r4", 32'(env_rf[4]), 32'hFFFE);
      run(mk(14, 0, 5, 0, 3), 0);
      #2 check("NOT r5", 32'(env_rf[5]), 32'hFF00);
      run(mk(16, 0, 10, 8, 9), 0);
      #2 check("LRSH r10", 32'(env_rf[10]), 32'h0800);
      run(mk(7, 14, 13, 12, 11), 5);
      #2 check("MUL lo r13", 32'(env_rf[13]), 32'h3400);
      check("MUL hi r14", 32'(env_rf[14]), 32'h0012);
      run(mk(8, 0, 15, 2, 1), 0);
      #2 check("DIV timeout r15 kept", 32'(env_rf[15]), 32'hABCD);
      run(mk(2, 0, 16, 2, 1), 0);
      run(mk(4, 0, 16, 2, 1), 0);
      #2 check("ADD after illegal r16", 32'(env_rf[16]), 32'h0008);

      vecs.push_back('{mk(0, 0, 17, 0, 3), 0});
      vecs.push_back('{mk(6, 0, 18, 0, 1), 0});
      for (int op = 9; op <= 13; op++) vecs.push_back('{mk(op, 0, 10 + op, 8, 3), 0});
      vecs.push_back('{mk(15, 0, 24, 3, 9), 0});
      vecs.push_back('{mk(8, 0, 25, 12, 9), 1});
      vecs.push_back('{mk(8, 0, 26, 11, 1), MdTimeout});
      vecs.push_back('{mk(8, 0, 27, 2, 0), 2});
      vecs.push_back('{mk(7, 28, 28, 12, 11), 2});
      vecs.push_back('{mk(4, 0, 0, 2, 1), 0});
      vecs.push_back('{mk(1, 0, 29, 2, 1), 0});
      vecs.push_back('{mk(3, 0, 29, 2, 1), 0});
      vecs.push_back('{mk(17, 0, 29, 2, 1), 0});
      vecs.push_back('{mk(63, 0, 29, 2, 1), 0});
      foreach (vecs[i]) run(vecs[i].ins, vecs[i].lat);
      #2;
      check("MOV r17", 32'(env_rf[17]), 32'h00FF);
      check("NEG r18", 32'(env_rf[18]), 32'hFFFB);
      check("XNOR r23", 32'(env_rf[23]), 32'h7F00);
      check("LLSH r24", 32'(env_rf[24]), 32'h0FF0);
      check("DIV r25", 32'(env_rf[25]), 32'h0040);
      check("DIV at limit r26", 32'(env_rf[26]), 32'h03A4);
      check("DIV by zero r27", 32'(env_rf[27]), 32'hFFFF);
      check("MUL same dst r28", 32'(env_rf[28]), 32'h0012);
      check("write r0", 32'(env_rf[0]), 32'h0008);

      stray = 1;
      repeat (4) tick();

      issue(mk(8, 0, 30, 2, 1), 0, d);
      repeat (10) tick();
      reset_now();
      repeat (2) tick();

      old7 = model_rf[7];
      issue(mk(7, 7, 6, 2, 1), 3, d);
      while (cyc < d) tick();
      reset_now();
      model_rf[7] = old7;
      repeat (2) tick();
      #2;
      check("WB_HI reset lo r6", 32'(env_rf[6]), 32'h000F);
      check("WB_HI reset hi r7", 32'(env_rf[7]), 32'h7777);

      run(mk(4, 0, 29, 2, 1), 0);
      #2 check("ADD after reset r29", 32'(env_rf[29]), 32'h0008);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
